cfsr_seq_checker: RTL and testbench
===================================

// Module: cfsr_seq_checker
// PURPOSE
//  Receive-side checker for the 4-bit feedback shift register sequence generator.
//  Takes the generator's parallel state word each valid cycle and self-synchronises
//  by seeding its own copy of the register. It then predicts every following word,
//  declares lock, and flags and counts mismatches.
//  Sits at the consumer end of the sequence link; used in-system and as a bench monitor.
// PARAMETERS
//  WIDTH       4        register / data width
//  TAPS        4'b1100  feedback mask; fb = ^(cur & TAPS) (x^4+x^3+1, period 15)
//  LOCK_COUNT  4        consecutive matches after seeding needed to declare lock (>=1)
//  UNLOCK_ERRS 3        consecutive mismatches while locked that force re-hunt (>=1)
//  CNT_W       16       error counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data carries a sequence word this cycle
//  in_data    in   WIDTH  received generator state word
//  clr_count  in   1      synchronous clear of err_count
//  locked     out  1      checker is synchronised (registered)
//  err_pulse  out  1      one-cycle flag: previous valid word mismatched while locked
//  err_count  out  CNT_W  saturating count of locked-state mismatches
// BEHAVIOUR
//  - next(x) = {x[WIDTH-2:0], ^(x & TAPS)}. All-zero is the lock-up word and never seeds.
//  - Reset (async, rst=1): state=HUNT, expected=0, good_cnt=0, bad_run=0, locked=0,
//    err_pulse=0, err_count=0. A reset mid-stream drops lock immediately.
//  - in_valid=0: no state change. err_pulse=0 the following cycle.
//  - HUNT, valid word:
//      nonzero word -> expected<=next(in_data), good_cnt<=0, go to VERIFY.
//      zero word    -> stay in HUNT.
//  - VERIFY, valid word:
//      in_data==expected -> expected<=next(in_data), good_cnt++.
//        The LOCK_COUNT-th match -> go to LOCKED; locked=1 from the next cycle.
//      mismatch, nonzero -> reseed: expected<=next(in_data), good_cnt<=0.
//      mismatch, zero    -> go to HUNT.
//      No errors are counted while in VERIFY.
//  - LOCKED, valid word:
//      match    -> expected<=next(expected), bad_run<=0.
//      mismatch -> err_pulse=1 next cycle, err_count+1 (saturates at all-ones).
//        expected<=next(expected) (flywheel; bad data is not reseeded), bad_run++.
//        bad_run reaching UNLOCK_ERRS -> go to HUNT, locked=0 next cycle, good_cnt<=0.
//  - Latency: every output is registered, one cycle after the valid word that caused it.
//    Lock asserts the cycle after the (LOCK_COUNT+1)-th valid word (seed + matches).
//  - clr_count: err_count<=0. If an error occurs in the same cycle, err_count<=1
//    (the error is never lost). err_pulse is unaffected by clr_count.
//  - The period wraps 1000->0001 naturally; no special case is needed.
// TESTING
//  T1 lock: after rst, drive 0001,0010,0100,1001,0011 with in_valid=1 ->
//     locked=1 the cycle after 0011; err_count=0.
//  T2 single error: locked, run continues 0110, then 0000 injected for 1101, then 1010 ->
//     one err_pulse, err_count=1, locked stays 1, 1010 matches (flywheel).
//  T3 unlock: while locked, inject 3 consecutive wrong words ->
//     err_count+=3, locked=0 after the 3rd; a clean restart from 0101 relocks after 5 words.
//  T4 gaps/wrap: locked stream with in_valid toggling 1010, over 2 full periods through 1000->0001 ->
//     no err_pulse, locked held throughout.
//  T5 zero/seed: 0000 words in HUNT -> stays HUNT; in VERIFY, 0001,0010,0111 ->
//     reseed on 0111, no count; then 1111,1110,1100,1000 -> lock.
//  T6 counter: CNT_W=2, 5 locked errors with UNLOCK_ERRS=8 -> err_count saturates at 3;
//     clr_count coincident with an error -> 1; rst asserted mid-lock -> all outputs 0 at once.

Source files
------------

// File: rtl/cfsr_seq_checker.sv
// Receive-side checker for a 4-bit feedback shift register sequence.
// Self-seeds from incoming words, verifies, locks and counts mismatches.
module cfsr_seq_checker #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(4'b1100),
    parameter int unsigned      LOCK_COUNT  = 4,
    parameter int unsigned      UNLOCK_ERRS = 3,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] expected_q;
    logic [GW-1:0]    good_q;
    logic [BW-1:0]    bad_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_count_q;

    logic [WIDTH-1:0] nxt_in_d;
    logic [WIDTH-1:0] nxt_exp_d;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             data_zero;
    logic             data_match;

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    assign nxt_in_d   = next_word(in_data);
    assign nxt_exp_d  = next_word(expected_q);
    assign data_zero  = (in_data == '0);
    assign data_match = (in_data == expected_q);
    assign cnt_inc_d  = (&err_count_q) ? err_count_q
                                       : err_count_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (clr_count) begin
                err_count_q <= '0;
            end
            if (in_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (!data_zero) begin
                            expected_q <= nxt_in_d;
                            good_q     <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (data_match) begin
                            expected_q <= nxt_in_d;
                            if (good_q == GOOD_LAST) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                                good_q   <= '0;
                            end else begin
                                good_q <= good_q + 1'b1;
                            end
                        end else if (!data_zero) begin
                            expected_q <= nxt_in_d;
                            good_q     <= '0;
                        end else begin
                            state_q <= HUNT;
                            good_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: bad data never reseeds while locked
                        expected_q <= nxt_exp_d;
                        if (data_match) begin
                            bad_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            err_count_q <= clr_count ? CNT_W'(1) : cnt_inc_d;
                            if (bad_q == BAD_LAST) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                good_q   <= '0;
                                bad_q    <= '0;
                            end else begin
                                bad_q <= bad_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_cfsr_seq_checker.sv
// Bench for cfsr_seq_checker: vector tables fed through a scoreboard queue,
// plus hand-written async reset checks on two parameterisations.
module tb_cfsr_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, v_a, clr_a, lk_a, ep_a;
    logic [3:0]  d_a;
    logic [15:0] ec_a;
    logic        rst_b, v_b, clr_b, lk_b, ep_b;
    logic [3:0]  d_b;
    logic [1:0]  ec_b;

    cfsr_seq_checker dut_a (
        .clk(clk), .rst(rst_a), .in_valid(v_a), .in_data(d_a),
        .clr_count(clr_a), .locked(lk_a), .err_pulse(ep_a), .err_count(ec_a)
    );

    cfsr_seq_checker #(.CNT_W(2), .UNLOCK_ERRS(8)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(v_b), .in_data(d_b),
        .clr_count(clr_b), .locked(lk_b), .err_pulse(ep_b), .err_count(ec_b)
    );

    typedef struct {
        bit         sel;
        bit         v;
        logic [3:0] d;
        bit         clr;
        bit         el;
        bit         ep;
        int         ec;
        int         id;
    } vec_t;

    vec_t ta[$];
    vec_t t5[$];
    vec_t t6[$];
    vec_t exp_q[$];
    vec_t cur;
    int   n_vec = 0;
    int   n_bad = 0;
    int   next_id = 0;

    function automatic vec_t mk(bit sel, bit v, logic [3:0] d, bit clr,
                                bit el, bit ep, int ec);
        vec_t r;
        r.sel = sel; r.v = v; r.d = d; r.clr = clr;
        r.el = el; r.ep = ep; r.ec = ec;
        r.id = next_id;
        next_id++;
        return r;
    endfunction

    // x^4+x^3+1 generator step
    function automatic logic [3:0] nx(logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    task automatic compare(string name, bit sel, bit el, bit ep, int ec);
        logic        gl, gp;
        logic [15:0] gc;
        gl = sel ? lk_b : lk_a;
        gp = sel ? ep_b : ep_a;
        gc = sel ? {14'b0, ec_b} : ec_a;
        n_vec++;
        if (gl !== el || gp !== ep || gc !== 16'(ec)) begin
            n_bad++;
            $display("FAIL %s: got locked=%0b pulse=%0b count=%0d, want locked=%0b pulse=%0b count=%0d",
                     name, gl, gp, gc, el, ep, ec);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            compare($sformatf("vec%0d", cur.id), cur.sel, cur.el, cur.ep, cur.ec);
        end
    end

    task automatic idle();
        v_a = 1'b0; clr_a = 1'b0; d_a = 4'h0;
        v_b = 1'b0; clr_b = 1'b0; d_b = 4'h0;
    endtask

    task automatic apply(input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            @(negedge clk);
            idle();
            if (t[i].sel) begin
                v_b = t[i].v; d_b = t[i].d; clr_b = t[i].clr;
            end else begin
                v_a = t[i].v; d_a = t[i].d; clr_a = t[i].clr;
            end
            exp_q.push_back(t[i]);
        end
        @(negedge clk);
        idle();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic async_reset(bit sel, string name);
        @(negedge clk);
        if (sel) rst_b = 1'b1;
        else     rst_a = 1'b1;
        #1;
        compare(name, sel, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] w;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle();

        // T1 lock, T2 single error, T3 unlock and relock
        ta.push_back(mk(0, 1, 4'h1, 0, 0, 0, 0));
        ta.push_back(mk(0, 1, 4'h2, 0, 0, 0, 0));
        ta.push_back(mk(0, 1, 4'h4, 0, 0, 0, 0));
        ta.push_back(mk(0, 1, 4'h9, 0, 0, 0, 0));
        ta.push_back(mk(0, 1, 4'h3, 0, 1, 0, 0));
        ta.push_back(mk(0, 1, 4'h6, 0, 1, 0, 0));
        ta.push_back(mk(0, 1, 4'h0, 0, 1, 1, 1));
        ta.push_back(mk(0, 1, 4'hA, 0, 1, 0, 1));
        ta.push_back(mk(0, 1, 4'hF, 0, 1, 1, 2));
        ta.push_back(mk(0, 1, 4'hF, 0, 1, 1, 3));
        ta.push_back(mk(0, 1, 4'hF, 0, 0, 1, 4));
        ta.push_back(mk(0, 1, 4'h5, 0, 0, 0, 4));
        ta.push_back(mk(0, 1, 4'hB, 0, 0, 0, 4));
        ta.push_back(mk(0, 1, 4'h7, 0, 0, 0, 4));
        ta.push_back(mk(0, 1, 4'hF, 0, 0, 0, 4));
        ta.push_back(mk(0, 1, 4'hE, 0, 1, 0, 4));
        // T4 gapped stream over two periods, then a lone clear
        w = 4'hC;
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                ta.push_back(mk(0, 1, w, 0, 1, 0, 4));
                w = nx(w);
            end else begin
                ta.push_back(mk(0, 0, ~w, 0, 1, 0, 4));
            end
        end
        ta.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0));
        ta.push_back(mk(0, 1, w, 0, 1, 0, 0));

        // T5 zero words in HUNT, reseed in VERIFY
        t5.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'h1, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'h2, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'h7, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'hF, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'hE, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'hC, 0, 0, 0, 0));
        t5.push_back(mk(0, 1, 4'h8, 0, 1, 0, 0));

        // T6 saturation and clear-with-error on the narrow counter
        t6.push_back(mk(1, 1, 4'h1, 0, 0, 0, 0));
        t6.push_back(mk(1, 1, 4'h2, 0, 0, 0, 0));
        t6.push_back(mk(1, 1, 4'h4, 0, 0, 0, 0));
        t6.push_back(mk(1, 1, 4'h9, 0, 0, 0, 0));
        t6.push_back(mk(1, 1, 4'h3, 0, 1, 0, 0));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 1));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 2));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 3));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 3));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 3));
        t6.push_back(mk(1, 1, 4'h7, 0, 1, 0, 3));
        t6.push_back(mk(1, 1, 4'h0, 1, 1, 1, 1));
        t6.push_back(mk(1, 0, 4'h0, 1, 1, 0, 0));
        t6.push_back(mk(1, 1, 4'h0, 0, 1, 1, 1));

        repeat (2) @(negedge clk);
        compare("reset_a", 1'b0, 1'b0, 1'b0, 0);
        compare("reset_b", 1'b1, 1'b0, 1'b0, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        apply(ta);
        async_reset(1'b0, "midlock_rst_a");
        apply(t5);
        apply(t6);
        async_reset(1'b1, "midlock_rst_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
